// File: rtl/encoder_pkg.sv
// Shared constants for the instruction encoder: op codes, DP command values, legality helper.
// The legality check is only applied when INSTR_ENCODER_CHECK_EN is defined.
package encoder_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_RSB = 4'b0011;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ADC = 4'b0101;
  localparam logic [3:0] CMD_SBC = 4'b0110;
  localparam logic [3:0] CMD_RSC = 4'b0111;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_TEQ = 4'b1001;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] CMD_BIC = 4'b1110;
  localparam logic [3:0] CMD_MVN = 4'b1111;

  localparam logic [3:0]  MUL_CMD_LIMIT = 4'b1000;
  localparam logic [31:0] NOP_WORD      = 32'hE1A00000;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } enc_state_e;

  // Compare commands without S make no sense; multiply only defines the low command range.
  function automatic logic is_illegal(logic [1:0] op, logic [3:0] cmd, logic s);
    logic mul_bad;
    logic cmp_bad;
    mul_bad = (op == OP_MUL) && (cmd > MUL_CMD_LIMIT);
    cmp_bad = (op == OP_DP) && (cmd >= CMD_TST) && (cmd <= CMD_CMN) && !s;
    return mul_bad || cmp_bad;
  endfunction

endpackage

// File: rtl/encode_word.sv
// Combinational field packer plus legality check for one instruction bundle.
// With INSTR_ENCODER_CHECK_EN undefined the illegal flag is tied low.
module encode_word
  import encoder_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [3:0]  cond_i,
  input  logic        imm_i,
  input  logic [3:0]  cmd_i,
  input  logic        s_i,
  input  logic [3:0]  rn_i,
  input  logic [3:0]  rd_i,
  input  logic [11:0] src2_i,
  input  logic [23:0] imm24_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic [5:0] funct;

  always_comb begin
    funct  = {imm_i, cmd_i, s_i};
    word_o = '0;
    unique case (op_i)
      // Memory: pre-index, up, word, no writeback; I is inverted in the encoding.
      OP_MEM: begin
        funct  = {~imm_i, 1'b1, 1'b1, 1'b0, 1'b0, s_i};
        word_o = {cond_i, op_i, funct, rn_i, rd_i, src2_i};
      end
      OP_BR: word_o = {cond_i, OP_BR, 2'b10, imm24_i};
      default: word_o = {cond_i, op_i, funct, rn_i, rd_i, src2_i};
    endcase
  end

`ifdef INSTR_ENCODER_CHECK_EN
  assign illegal_o = is_illegal(op_i, cmd_i, s_i);
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder and imem writer: packs field bundles into words written at consecutive
// addresses from BASE_ADDR. INSTR_ENCODER_CHECK_EN enables NOP substitution and err reporting.
module instr_encoder
  import encoder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_last_i,
  input  logic [1:0]        in_op_i,
  input  logic [3:0]        in_cond_i,
  input  logic              in_i_i,
  input  logic [3:0]        in_cmd_i,
  input  logic              in_s_i,
  input  logic [3:0]        in_rn_i,
  input  logic [3:0]        in_rd_i,
  input  logic [11:0]       in_src2_i,
  input  logic [23:0]       in_imm24_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              full_o,
  output logic [ADDR_W:0]   count_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] err_addr_o
);

  localparam logic [ADDR_W-1:0] AddrBase = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] AddrLast = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CountMax = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CountOne = (ADDR_W + 1)'(1);

  enc_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [ADDR_W-1:0] err_addr_q;
  logic [ADDR_W:0]   count_q;
  logic [31:0]       imem_wdata_q;
  logic              imem_we_q;
  logic              done_q;
  logic              full_q;
  logic              err_q;

  logic [31:0] word;
  logic [31:0] wdata_sel;
  logic        illegal;
  logic        accept;
  logic        at_last_addr;

  encode_word u_encode_word (
    .op_i      (in_op_i),
    .cond_i    (in_cond_i),
    .imm_i     (in_i_i),
    .cmd_i     (in_cmd_i),
    .s_i       (in_s_i),
    .rn_i      (in_rn_i),
    .rd_i      (in_rd_i),
    .src2_i    (in_src2_i),
    .imm24_i   (in_imm24_i),
    .word_o    (word),
    .illegal_o (illegal)
  );

  assign wdata_sel    = illegal ? NOP_WORD : word;
  assign accept       = (state_q == StLoad) && in_valid_i;
  assign at_last_addr = (addr_q == AddrLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      done_q       <= 1'b0;
      full_q       <= 1'b0;
      count_q      <= '0;
      err_q        <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      imem_we_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q    <= StLoad;
            addr_q     <= AddrBase;
            count_q    <= '0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
          end
        end
        StLoad: begin
          if (accept) begin
            imem_we_q    <= 1'b1;
            imem_addr_q  <= addr_q;
            imem_wdata_q <= wdata_sel;
            addr_q       <= addr_q + AddrOne;
            if (count_q != CountMax) begin
              count_q <= count_q + CountOne;
            end
            if (illegal) begin
              err_q <= 1'b1;
              if (!err_q) begin
                err_addr_q <= addr_q;
              end
            end
            // Capacity wins over in_last for the full flag when both end the load.
            if (in_last_i || at_last_addr) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              if (at_last_addr) begin
                full_q <= 1'b1;
              end
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o   = (state_q == StLoad);
  assign busy_o       = (state_q != StIdle);
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign done_o       = done_q;
  assign full_o       = full_q;
  assign count_o      = count_q;
  assign err_o        = err_q;
  assign err_addr_o   = err_addr_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Field-level instruction encoder and instruction-memory writer; the inverse of the control decoder. It accepts decoded instruction fields (Op, condition, command, S/I/L bits, registers, operand) over a valid/ready stream and packs them into 32-bit words. It writes each word into instruction memory at consecutive word addresses. It sits between the test/boot program loader and the imem write port.

## Interface
- ADDR_W, 8, imem word-address width; load capacity is 2^ADDR_W words
- BASE_ADDR, 0, first word address written after `start`
- clk  input  1  clock, rising edge
- reset  input  1  reset, asynchronous, active-low
- start  input  1  begin a load; honoured only in IDLE
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder accepts the bundle this cycle
- in_last  input  1  final instruction of the load
- in_op  input  2  00 data-proc, 01 memory, 10 branch, 11 multiply/long
- in_cond  input  4  condition field, bits [31:28]
- in_i  input  1  Src2 is immediate
- in_cmd  input  4  command, Funct[4:1] (DP/multiply)
- in_s  input  1  S bit (DP/multiply); L bit (memory)
- in_rn, in_rd  input  4 each  register fields
- in_src2  input  12  operand2 / offset
- in_imm24  input  24  branch offset
- imem_we  output  1  write strobe, one cycle per word
- imem_addr  output  ADDR_W  word address
- imem_wdata  output  32  encoded word
- busy  output  1  state ≠ IDLE
- done  output  1  one-cycle pulse at end of load
- full  output  1  sticky; load ended by capacity
- count  output  ADDR_W+1  words written in the current or last load
- err, err_addr  output  1 / ADDR_W  illegal-encoding flag and address (CHECK_EN only)

## Operation
- Packing: word = {cond, op, funct, rn, rd, src2}.
  - op 00/11: funct = {in_i, in_cmd, in_s}.
  - op 01: funct = {~in_i, 1, 1, 0, 0, in_s}, i.e. pre-index, up, word, no writeback.
  - op 10: word = {cond, 2'b10, 2'b10, imm24}.
- FSM states: IDLE, LOAD, DONE.
  - IDLE→LOAD on `start`. Address is set to BASE_ADDR; count, full and err are cleared.
  - LOAD: in_ready=1. Each handshake (in_valid & in_ready) registers the word and address. The address increments modulo 2^ADDR_W.
  - LOAD→DONE when the accepted bundle has in_last=1, or when its address is 2^ADDR_W−1. The capacity case sets `full`; in_last at the same time still sets `full`.
  - DONE: in_ready=0, done=1, then →IDLE.
- `start` is ignored outside IDLE. in_valid is ignored outside LOAD.
- count increments on each imem_we and saturates at 2^ADDR_W.
- Reset values: all outputs 0, imem_addr 0, state IDLE.

## Timing
- Handshake in cycle N → imem_we=1 in N+1 with the registered addr/wdata. Throughput is one word per cycle.
- Last accepted in N → DONE in N+1, with done and the last imem_we in the same cycle. IDLE in N+2. The earliest next `start` is sampled in N+2.
- in_ready is combinational from state only, never from in_valid.
- Reset asserted mid-load: imem_we drops immediately (asynchronous). The partial load is abandoned and count is cleared.

## Configuration
- INSTR_ENCODER_CHECK_EN defined:
  - Illegal bundles still consume an address.
  - imem_wdata is replaced by NOP 32'hE1A00000.
  - err is set (sticky until the next `start`).
  - err_addr latches the first offending address.
- Illegal bundles are:
  - op 11 with cmd > 1000;
  - op 00 with cmd in 1000–1011 and S=0.
- Macro undefined: raw packing is always written; err and err_addr are tied to 0.

## Structure
- Shared package `encoder_pkg`:
  - Op codes (OP_DP, OP_MEM, OP_BR, OP_MUL).
  - DP command constants (AND 0000, EOR 0001, SUB 0010, RSB 0011, ADD 0100, ADC 0101, SBC 0110, RSC 0111, TST–CMN 1000–1011, ORR 1100, MOV/shift 1101, BIC 1110, MVN 1111).
  - Multiply command range limit 1000 and the NOP constant.
- Sub-module `encode_word`: combinational packer plus legality check. The top holds the FSM, address counter and output registers.

## Test plan
- ADD r1,r2,#5 (op00, I=1, cmd0100, S0, cond E, rn2, rd1, src2 005), in_last → imem_we at BASE_ADDR, wdata E2821005, done in the same cycle, count=1.
- LDR r3,[r4,#8] (op01, I=1, L=1), then B (op10, imm24 000010, cond E, last) back-to-back → E5943008 at addr 0, EA000010 at addr 1, on consecutive cycles.
- op11 cmd0000 rn1 rd2 src2 003 → EC012003.
- CHECK_EN, op11 cmd1111 as the 3rd word → addr 2 gets E1A00000, err=1, err_addr=2. Without the macro the raw word EFxxxxxx is written and err=0.
- ADDR_W=2, 5 bundles streamed without last → 4 writes (addr 0–3), done after the 4th, full=1, 5th bundle not accepted.
- Reset pulled low the cycle after the 2nd handshake → imem_we=0 immediately, busy=0, count=0; a new `start` resumes at BASE_ADDR.
